// File: rtl/falling_cubes_pkg.sv
// Shared definitions for the falling-cubes game: generator FSM states, LFSR taps and
// the column-bucket map also used by the position selector.
package falling_cubes_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    GENERA = 1'b1
  } gen_state_t;

  localparam logic [15:0] SEED_DEFAULT      = 16'hACE1;
  localparam int          MAX_VALUE_DEFAULT = 30;
  localparam int          REJ_LIMIT_DEFAULT = 15;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  // Upper bound (inclusive) of each column bucket; 28-30 is the last one.
  localparam logic [4:0] COL_FIN_0 = 5'd3;
  localparam logic [4:0] COL_FIN_1 = 5'd6;
  localparam logic [4:0] COL_FIN_2 = 5'd9;
  localparam logic [4:0] COL_FIN_3 = 5'd12;
  localparam logic [4:0] COL_FIN_4 = 5'd15;
  localparam logic [4:0] COL_FIN_5 = 5'd19;
  localparam logic [4:0] COL_FIN_6 = 5'd23;
  localparam logic [4:0] COL_FIN_7 = 5'd27;

  localparam logic [3:0] COLUMNA_NINGUNA = 4'hF;

  function automatic logic [3:0] columna_de(input logic [4:0] x);
    logic [3:0] col;
    if      (x <= COL_FIN_0) col = 4'd0;
    else if (x <= COL_FIN_1) col = 4'd1;
    else if (x <= COL_FIN_2) col = 4'd2;
    else if (x <= COL_FIN_3) col = 4'd3;
    else if (x <= COL_FIN_4) col = 4'd4;
    else if (x <= COL_FIN_5) col = 4'd5;
    else if (x <= COL_FIN_6) col = 4'd6;
    else if (x <= COL_FIN_7) col = 4'd7;
    else                     col = 4'd8;
    return col;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with a seed load; a zero seed is replaced by SEED
// so the register can never lock up in the all-zero state.
module lfsr16
  import falling_cubes_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        carga,
  input  logic [15:0] semilla,
  output logic [15:0] q
);

  logic realim;

  assign realim = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= SEED;
    else if (carga)
      q <= (semilla == 16'h0000) ? SEED : semilla;
    else
      q <= {q[14:0], realim};
  end

endmodule

// File: rtl/generador_aleatorio.sv
// Pseudo-random column value source: LFSR candidates accepted through a request/valid handshake.
// Define SIN_REPETIR_EN to also reject candidates falling in the last delivered column bucket.
module generador_aleatorio
  import falling_cubes_pkg::*;
#(
  parameter logic [15:0] SEED      = SEED_DEFAULT,
  parameter int          MAX_VALUE = MAX_VALUE_DEFAULT,
  parameter int          REJ_LIMIT = REJ_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        semilla_carga,
  input  logic [15:0] semilla,
  input  logic        solicitud,
  output logic [4:0]  aleatorio,
  output logic        valido,
  output logic        ocupado
);

  localparam int            RW      = (REJ_LIMIT > 0) ? $clog2(REJ_LIMIT + 1) : 1;
  localparam logic [4:0]    MAX_V   = 5'(MAX_VALUE);
  localparam logic [RW-1:0] REJ_MAX = RW'(REJ_LIMIT);

  gen_state_t    state_q, state_d;
  logic [RW-1:0] rejcnt_q, rejcnt_d;
  logic [4:0]    aleatorio_d;
  logic          valido_d;
  logic [15:0]   lfsr_q;
  logic [4:0]    candidato;
  logic          en_rango, forzado, repetido, aceptar;
  logic          lfsr_alto_unused;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .carga   (semilla_carga),
    .semilla (semilla),
    .q       (lfsr_q)
  );

  assign candidato        = lfsr_q[4:0];
  assign lfsr_alto_unused = ^lfsr_q[15:5];
  assign en_rango         = (candidato <= MAX_V);
  assign forzado          = (rejcnt_q == REJ_MAX);
  assign aceptar          = forzado || (en_rango && !repetido);
  assign ocupado          = (state_q != IDLE);

`ifdef SIN_REPETIR_EN
  logic [3:0] ultima_q, ultima_d;

  assign repetido = (columna_de(candidato) == ultima_q);

  always_comb begin
    ultima_d = ultima_q;
    if (valido_d)
      ultima_d = columna_de(aleatorio_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ultima_q <= COLUMNA_NINGUNA;
    else
      ultima_q <= ultima_d;
  end
`else
  assign repetido = 1'b0;
`endif

  // A seed load preempts both request intake and any generation in flight.
  always_comb begin
    state_d     = state_q;
    rejcnt_d    = rejcnt_q;
    aleatorio_d = aleatorio;
    valido_d    = 1'b0;
    if (semilla_carga) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (solicitud) begin
            state_d  = GENERA;
            rejcnt_d = '0;
          end
        end
        GENERA: begin
          if (aceptar) begin
            state_d     = IDLE;
            valido_d    = 1'b1;
            aleatorio_d = (forzado && !en_rango) ? MAX_V : candidato;
          end else begin
            rejcnt_d = rejcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rejcnt_q  <= '0;
      aleatorio <= 5'd0;
      valido    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rejcnt_q  <= rejcnt_d;
      aleatorio <= aleatorio_d;
      valido    <= valido_d;
    end
  end

endmodule

// File: tb/tb_generador_aleatorio.sv
// Scoreboard bench for generador_aleatorio: two instances (MAX_VALUE 30 and 3) share stimulus;
// a request-level reference model predicts each delivered value and its arrival cycle.
module tb_generador_aleatorio;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          REJ_LIMIT = 15;
  localparam int          NREQ      = 2000;
  localparam int          COL_LIM [9] = '{3, 6, 9, 12, 15, 19, 23, 27, 30};

`ifdef SIN_REPETIR_EN
  localparam bit NOREP = 1'b1;
`else
  localparam bit NOREP = 1'b0;
`endif

  typedef struct {
    logic [4:0] val;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        semilla_carga = 1'b0;
  logic [15:0] semilla = 16'h0000;
  logic        solicitud = 1'b0;
  logic [4:0]  a30, a3;
  logic        valido30, valido3, ocupado30, ocupado3;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] ref_lfsr = SEED;
  logic [3:0]  last0 = 4'hF;
  logic [3:0]  last1 = 4'hF;
  logic [4:0]  exp_a3 = 5'd0;
  logic        prev_v0 = 1'b0;
  logic        prev_v1 = 1'b0;
  exp_t        q0[$];
  exp_t        q1[$];

  generador_aleatorio #(.SEED(SEED), .MAX_VALUE(30), .REJ_LIMIT(REJ_LIMIT)) dut30 (
    .clk(clk), .reset_n(reset_n), .semilla_carga(semilla_carga), .semilla(semilla),
    .solicitud(solicitud), .aleatorio(a30), .valido(valido30), .ocupado(ocupado30)
  );

  generador_aleatorio #(.SEED(SEED), .MAX_VALUE(3), .REJ_LIMIT(REJ_LIMIT)) dut3 (
    .clk(clk), .reset_n(reset_n), .semilla_carga(semilla_carga), .semilla(semilla),
    .solicitud(solicitud), .aleatorio(a3), .valido(valido3), .ocupado(ocupado3)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] bucket(input logic [4:0] c);
    for (int i = 0; i < 9; i++)
      if (int'(c) <= COL_LIM[i]) return 4'(i);
    return 4'd8;
  endfunction

  // Walks the candidate stream that follows the request edge until one is accepted.
  function automatic void predict(input logic [15:0] l0, input int maxv, input logic [3:0] last,
                                  output logic [4:0] v, output int r);
    logic [15:0] l;
    logic [4:0]  c;
    l = l0;
    v = 5'd0;
    r = 0;
    for (int i = 0; i <= REJ_LIMIT; i++) begin
      l = lstep(l);
      c = l[4:0];
      if (i == REJ_LIMIT) begin
        v = (int'(c) > maxv) ? 5'(maxv) : c;
        r = i;
        return;
      end
      if (int'(c) <= maxv && !(NOREP && bucket(c) == last)) begin
        v = c;
        r = i;
        return;
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)           ref_lfsr = SEED;
    else if (semilla_carga) ref_lfsr = (semilla == 16'h0000) ? SEED : semilla;
    else                    ref_lfsr = lstep(ref_lfsr);
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one edge worth of inputs; called just after an edge, returns just after the next.
  task automatic applyStimulus(input logic req, input logic carga, input logic [15:0] s);
    solicitud     = req;
    semilla_carga = carga;
    semilla       = s;
    @(posedge clk);
    #1;
    solicitud     = 1'b0;
    semilla_carga = 1'b0;
  endtask

  task automatic doRequest(output int rmax);
    exp_t       e;
    logic [4:0] v;
    int         r0, r1;
    predict(ref_lfsr, 30, last0, v, r0);
    e.val = v; e.cyc = cyc + 2 + r0; q0.push_back(e); last0 = bucket(v);
    predict(ref_lfsr, 3, last1, v, r1);
    e.val = v; e.cyc = cyc + 2 + r1; q1.push_back(e); last1 = bucket(v); exp_a3 = v;
    rmax = (r0 > r1) ? r0 : r1;
    applyStimulus(1'b1, 1'b0, 16'h0000);
  endtask

  task automatic waitIdle(input int rmax);
    repeat (rmax + 1) @(posedge clk);
    #1;
  endtask

  task automatic monitorPort(input int idx, input logic v, input logic [4:0] a, input int maxv,
                             input logic prev_v);
    exp_t e;
    bit   empty;
    empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (!empty) begin
      if (idx == 0) e = q0[0];
      else          e = q1[0];
    end
    if (v) begin
      checkOutput($sformatf("pulso_u%0d", idx), 32'(prev_v), 32'd0);
      if (empty) begin
        checkOutput($sformatf("valido_espurio_u%0d", idx), 32'd1, 32'd0);
      end else begin
        checkOutput($sformatf("valor_u%0d", idx), 32'(a), 32'(e.val));
        checkOutput($sformatf("latencia_u%0d", idx), 32'(cyc), 32'(e.cyc));
        checkOutput($sformatf("rango_u%0d", idx), 32'(int'(a) <= maxv), 32'd1);
        if (idx == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
      end
    end else if (!empty && cyc >= e.cyc) begin
      checkOutput($sformatf("timeout_u%0d", idx), 32'd0, 32'd1);
      if (idx == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      monitorPort(0, valido30, a30, 30, prev_v0);
      monitorPort(1, valido3, a3, 3, prev_v1);
    end
    prev_v0 = valido30;
    prev_v1 = valido3;
  end

  initial begin
    int rm;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_aleatorio30", 32'(a30), 32'd0);
    checkOutput("reset_valido30", 32'(valido30), 32'd0);
    checkOutput("reset_ocupado30", 32'(ocupado30), 32'd0);
    checkOutput("reset_aleatorio3", 32'(a3), 32'd0);
    checkOutput("reset_valido3", 32'(valido3), 32'd0);
    checkOutput("reset_ocupado3", 32'(ocupado3), 32'd0);
    checkOutput("reset_lfsr", 32'(dut30.u_lfsr.q), 32'h0000ACE1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    doRequest(rm);
    waitIdle(rm);

    // Seed 0x0001: the request edge steps to 0x0002, so 2 is delivered two edges later.
    applyStimulus(1'b0, 1'b1, 16'h0001);
    doRequest(rm);
    @(posedge clk);
    @(negedge clk);
    checkOutput("seed1_valido", 32'(valido30), 32'd1);
    checkOutput("seed1_valor", 32'(a30), 32'd2);
    waitIdle(rm);

    // Seed 0x800F: 31 is rejected first, 30 follows one cycle later.
    applyStimulus(1'b0, 1'b1, 16'h800F);
    doRequest(rm);
    @(negedge clk);
    checkOutput("seed800f_ocupado", 32'(ocupado30), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("seed800f_sin_valido", 32'(valido30), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("seed800f_valido", 32'(valido30), 32'd1);
    checkOutput("seed800f_valor", 32'(a30), 32'd30);
    waitIdle(rm);

    // Load during GENERA aborts the request with no delivery.
    applyStimulus(1'b0, 1'b1, 16'h800F);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h5A5A);
    @(negedge clk);
    checkOutput("abort_ocupado30", 32'(ocupado30), 32'd0);
    checkOutput("abort_ocupado3", 32'(ocupado3), 32'd0);
    checkOutput("abort_aleatorio30", 32'(a30), 32'd30);
    checkOutput("abort_aleatorio3", 32'(a3), 32'(exp_a3));
    repeat (4) @(posedge clk);
    #1;

    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("seed0_lfsr", 32'(dut30.u_lfsr.q), 32'h0000ACE1);
    doRequest(rm);
    waitIdle(rm);

    for (int n = 0; n < NREQ; n++) begin
      if ($urandom_range(0, 7) == 0)
        applyStimulus(1'b0, 1'b1, ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 16'h0000);
      doRequest(rm);
      waitIdle(rm);
    end

    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("pendientes", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
